// File: rtl/tv_pkg.sv
// Shared state encoding and vector-word field layout for the test-vector checker.
// Pure declarations: no latency and no flow control.
package tv_pkg;

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} tv_state_e;

  // Vector word layout, MSB first: {stim, expected, mask}
  function automatic int word_w(input int in_w, input int out_w);
    return in_w + 2 * out_w;
  endfunction

  function automatic int stim_lsb(input int out_w);
    return 2 * out_w;
  endfunction

  function automatic int exp_lsb(input int out_w);
    return out_w;
  endfunction

  function automatic int mask_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/tv_mem.sv
// Vector storage: one synchronous write port and one asynchronous read port.
// Writes land on the next clk edge, reads are combinational; there is no backpressure.
module tv_mem #(
  parameter int W      = 24,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  // Out-of-range addresses (DEPTH not a power of two) are dropped
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tv_checker.sv
// Test-vector sequencer/checker: drives stimulus and compares the masked response after LATENCY cycles.
// Each vector costs 2+LATENCY cycles; loads are dropped while busy, and start is ignored while busy.
module tv_checker
  import tv_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [IN_W+2*OUT_W-1:0] ld_data,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W:0]         num_vec,
  input  logic                    stop_on_error,
  output logic [IN_W-1:0]         dut_in,
  input  logic [OUT_W-1:0]        dut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    aborted,
  output logic [CNT_W-1:0]        err_count,
  output logic                    first_err_valid,
  output logic [ADDR_W-1:0]       first_err_idx,
  output logic [OUT_W-1:0]        first_err_bits
);

  localparam int W     = word_w(IN_W, OUT_W);
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

  tv_state_e         state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   n_q;
  logic              soe_q;
  logic [LAT_W-1:0]  wait_cnt;

  logic [W-1:0]      rd_word;
  logic [IN_W-1:0]   stim_v;
  logic [OUT_W-1:0]  exp_v, mask_v, diff;
  logic              is_err, is_last, finish_chk;
  logic [ADDR_W:0]   n_sel;
  logic [CNT_W-1:0]  err_inc;

  tv_mem #(.W(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (ld_en && !busy),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (idx),
    .rdata (rd_word)
  );

  assign stim_v     = rd_word[stim_lsb(OUT_W) +: IN_W];
  assign exp_v      = rd_word[exp_lsb(OUT_W) +: OUT_W];
  assign mask_v     = rd_word[mask_lsb() +: OUT_W];
  assign diff       = (dut_out ^ exp_v) & mask_v;
  assign is_err     = |diff;
  assign is_last    = ({1'b0, idx} == (n_q - (ADDR_W + 1)'(1)));
  assign finish_chk = is_last || (is_err && soe_q);
  assign n_sel      = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
  assign err_inc    = (&err_count) ? err_count : err_count + CNT_W'(1);
  assign busy       = (state == APPLY) || (state == WAIT) || (state == CHECK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (n_sel == '0) ? DONE : APPLY;
      APPLY:      state_nxt = abort ? DONE : ((LATENCY > 0) ? WAIT : CHECK);
      WAIT:       state_nxt = abort ? DONE : ((wait_cnt == LAT_W'(1)) ? CHECK : WAIT);
      CHECK:      state_nxt = (abort || finish_chk) ? DONE : APPLY;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx             <= '0;
      n_q             <= '0;
      soe_q           <= 1'b0;
      wait_cnt        <= '0;
      dut_in          <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
      aborted         <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
      first_err_bits  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_bits  <= '0;
            aborted         <= 1'b0;
            pass            <= (n_sel == '0);
            done            <= (n_sel == '0);
            n_q             <= n_sel;
            soe_q           <= stop_on_error;
            idx             <= '0;
          end
        end
        APPLY, WAIT, CHECK: begin
          if (abort) begin
            // Abort ends the run without evaluating the vector in flight
            done    <= 1'b1;
            aborted <= 1'b1;
            pass    <= 1'b0;
          end else if (state == APPLY) begin
            dut_in   <= stim_v;
            wait_cnt <= LAT_W'(LATENCY);
          end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end else begin
            if (is_err) begin
              err_count <= err_inc;
              if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_idx   <= idx;
                first_err_bits  <= diff;
              end
            end
            if (finish_chk) begin
              done <= 1'b1;
              pass <= (err_count == '0) && !is_err;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tv_checker.sv
// Directed bench: four checker instances (L0, CNT_W=2, L2, L1) share one load bus.
// Responses are sampled 1 time unit after each rising edge.
module tb_tv_checker;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ld_en = 1'b0;
  logic [2:0] ld_addr = '0;
  logic [11:0] ld_data = '0;
  logic       abort = 1'b0;
  logic [3:0] num_vec = '0;
  logic       stop_on_error = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;

  logic [3:0] dut_in_a, dut_in_b, dut_in_c, dut_in_d;
  logic [3:0] dut_out_a, dut_out_b, dut_out_c, dut_out_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       done_a, done_b, done_c, done_d;
  logic       pass_a, pass_b, pass_c, pass_d;
  logic       abt_a, abt_b, abt_c, abt_d;
  logic [15:0] err_a, err_c, err_d;
  logic [1:0]  err_b;
  logic       fev_a, fev_b, fev_c, fev_d;
  logic [2:0] fei_a, fei_b, fei_c, fei_d;
  logic [3:0] feb_a, feb_b, feb_c, feb_d;

  logic [3:0] c_s1 = '0, c_s2 = '0, d_s1 = '0, d_s2 = '0;

  int total = 0;
  int bad = 0;
  int cyc;

  always #5 clk = ~clk;

  assign dut_out_a = ~dut_in_a;
  assign dut_out_b = ~dut_in_b;
  always @(posedge clk) begin
    c_s1 <= ~dut_in_c;
    c_s2 <= c_s1;
    d_s1 <= ~dut_in_d;
    d_s2 <= d_s1;
  end
  assign dut_out_c = c_s2;
  assign dut_out_d = d_s2;

  tv_checker #(.IN_W(4), .OUT_W(4), .DEPTH(8), .LATENCY(0), .CNT_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start_a), .abort(abort), .num_vec(num_vec), .stop_on_error(stop_on_error),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .aborted(abt_a), .err_count(err_a), .first_err_valid(fev_a), .first_err_idx(fei_a),
    .first_err_bits(feb_a));

  tv_checker #(.IN_W(4), .OUT_W(4), .DEPTH(8), .LATENCY(0), .CNT_W(2)) u_b (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start_b), .abort(abort), .num_vec(num_vec), .stop_on_error(stop_on_error),
    .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .aborted(abt_b), .err_count(err_b), .first_err_valid(fev_b), .first_err_idx(fei_b),
    .first_err_bits(feb_b));

  tv_checker #(.IN_W(4), .OUT_W(4), .DEPTH(8), .LATENCY(2), .CNT_W(16)) u_c (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start_c), .abort(abort), .num_vec(num_vec), .stop_on_error(stop_on_error),
    .dut_in(dut_in_c), .dut_out(dut_out_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .aborted(abt_c), .err_count(err_c), .first_err_valid(fev_c), .first_err_idx(fei_c),
    .first_err_bits(feb_c));

  tv_checker #(.IN_W(4), .OUT_W(4), .DEPTH(8), .LATENCY(1), .CNT_W(16)) u_d (
    .clk(clk), .reset_n(reset_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start_d), .abort(abort), .num_vec(num_vec), .stop_on_error(stop_on_error),
    .dut_in(dut_in_d), .dut_out(dut_out_d), .busy(busy_d), .done(done_d), .pass(pass_d),
    .aborted(abt_d), .err_count(err_d), .first_err_valid(fev_d), .first_err_idx(fei_d),
    .first_err_bits(feb_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [3:0] st, input logic [3:0] ex,
                      input logic [3:0] mk);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = {st, ex, mk};
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic set_start(input int s, input logic v);
    case (s)
      0: start_a = v;
      1: start_b = v;
      2: start_c = v;
      default: start_d = v;
    endcase
  endtask

  function automatic logic sel_done(input int s);
    case (s)
      0: return done_a;
      1: return done_b;
      2: return done_c;
      default: return done_d;
    endcase
  endfunction

  // Returns the number of rising edges from the start edge until done is seen
  task automatic run(input int s, input logic [3:0] nv, input logic soe, output int c);
    num_vec = nv;
    stop_on_error = soe;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    c = 1;
    while (!sel_done(s) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    #12;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_fev", fev_a, 0);
    chk("rst_dut_in", dut_in_a, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) load(3'(i), 4'(i), ~4'(i), 4'hF);

    // Clean run
    run(0, 4'd4, 1'b0, cyc);
    chk("clean_cyc", cyc, 9);
    chk("clean_pass", pass_a, 1);
    chk("clean_err", err_a, 0);
    chk("clean_fev", fev_a, 0);
    chk("clean_busy", busy_a, 0);
    chk("clean_dut_in", dut_in_a, 3);

    // Registered two-stage DUT with matching and mismatching latency
    run(2, 4'd3, 1'b0, cyc);
    chk("lat2_cyc", cyc, 13);
    chk("lat2_pass", pass_c, 1);
    run(3, 4'd3, 1'b0, cyc);
    chk("lat1_errs", (err_d != 0), 1);
    chk("lat1_pass", pass_d, 0);

    // Async reset while in WAIT of vector 1
    num_vec = 4'd3;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("pre_rst_busy", busy_c, 1);
    chk("pre_rst_dut_in", dut_in_c, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy_c, 0);
    chk("arst_dut_in", dut_in_c, 0);
    chk("arst_done", done_c, 0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    run(2, 4'd3, 1'b0, cyc);
    chk("rerun_cyc", cyc, 13);
    chk("rerun_pass", pass_c, 1);

    // num_vec clamps to DEPTH, and zero vectors finishes immediately
    run(0, 4'd12, 1'b0, cyc);
    chk("clamp_cyc", cyc, 17);
    chk("clamp_pass", pass_a, 1);
    chk("clamp_dut_in", dut_in_a, 7);
    run(0, 4'd0, 1'b0, cyc);
    chk("zero_cyc", cyc, 1);
    chk("zero_pass", pass_a, 1);

    // Errors at vectors 2 and 5 on bit 1
    load(3'd2, 4'd2, ~4'd2 ^ 4'b0010, 4'hF);
    load(3'd5, 4'd5, ~4'd5 ^ 4'b0010, 4'hF);
    run(0, 4'd6, 1'b0, cyc);
    chk("err_cnt", err_a, 2);
    chk("err_fev", fev_a, 1);
    chk("err_idx", fei_a, 2);
    chk("err_bits", feb_a, 4'b0010);
    chk("err_pass", pass_a, 0);

    // A load issued while busy must not repair vector 2
    num_vec = 4'd8;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    ld_en = 1'b1;
    ld_addr = 3'd2;
    ld_data = {4'd2, ~4'd2, 4'hF};
    @(posedge clk); #1;
    ld_en = 1'b0;
    cyc = 2;
    while (!done_a && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("busy_ld_cyc", cyc, 17);
    chk("busy_ld_err", err_a, 2);
    chk("busy_ld_idx", fei_a, 2);

    // Masking out the bad bit hides the errors
    load(3'd2, 4'd2, ~4'd2 ^ 4'b0010, 4'b1101);
    load(3'd5, 4'd5, ~4'd5 ^ 4'b0010, 4'b1101);
    run(0, 4'd6, 1'b0, cyc);
    chk("mask_pass", pass_a, 1);
    chk("mask_err", err_a, 0);

    // Stop on error at vector 1
    load(3'd1, 4'd1, ~4'd1 ^ 4'b0100, 4'hF);
    run(0, 4'd8, 1'b1, cyc);
    chk("soe_cyc", cyc, 5);
    chk("soe_err", err_a, 1);
    chk("soe_idx", fei_a, 1);
    chk("soe_bits", feb_a, 4'b0100);

    // Abort while applying vector 2
    num_vec = 4'd8;
    stop_on_error = 1'b0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("pre_abort_busy", busy_a, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_aborted", abt_a, 1);
    chk("abort_done", done_a, 1);
    chk("abort_pass", pass_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_err", err_a, 1);

    // Saturation with CNT_W=2 and five errors
    for (int i = 0; i < 5; i++) load(3'(i), 4'(i), ~4'(i) ^ 4'b0001, 4'hF);
    load(3'd5, 4'd5, ~4'd5, 4'hF);
    run(1, 4'd8, 1'b0, cyc);
    chk("sat_cyc", cyc, 17);
    chk("sat_err", err_b, 3);
    chk("sat_idx", fei_b, 0);
    chk("sat_bits", feb_b, 4'b0001);
    chk("sat_pass", pass_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tv_checker.md
Name: tv_checker

Overview:
- Synthesizable, parametrised test-vector sequencer/checker for on-chip or FPGA self-test of small combinational or pipelined blocks.
- Holds a vector memory of {stimulus, expected, care-mask} words and drives stimulus onto the DUT.
- After a configurable latency it compares the DUT response under the mask and reports error count, first failing index and pass/fail.
- Sits beside the block under test, loaded over a simple write port while idle.

Parameters:
- IN_W, 8, stimulus width (dut_in).
- OUT_W, 8, response width (dut_out, expected, mask).
- DEPTH, 16, vector memory entries, >=1.
- LATENCY, 0, extra cycles between stimulus update and response sampling (0 = combinational DUT).
- CNT_W, 16, error counter width.
- ADDR_W, $clog2(DEPTH) (min 1), derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_en  in  1  write vector memory; ignored while busy.
- ld_addr  in  ADDR_W  write address.
- ld_data  in  IN_W+2*OUT_W  packed {stim, expected, mask}, stim in MSBs.
- start  in  1  begin run; sampled only in IDLE or DONE.
- abort  in  1  terminate run.
- num_vec  in  ADDR_W+1  vectors to run; sampled at start.
- stop_on_error  in  1  halt at first mismatch; sampled at start.
- dut_in  out  IN_W  registered stimulus to the DUT.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  valid with done.
- aborted  out  1  run ended by abort.
- err_count  out  CNT_W  masked mismatches, saturating.
- first_err_valid  out  1  at least one error recorded.
- first_err_idx  out  ADDR_W  index of first failing vector.
- first_err_bits  out  OUT_W  masked XOR at the first failure.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, index 0, wait counter 0. Memory contents are not reset.
- FSM states: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE/DONE, start=1:
  - Clear err_count, first_err_*, pass, aborted and done.
  - Latch n = min(num_vec, DEPTH) and stop_on_error; index <= 0.
  - If n==0, go to DONE with pass=1. Otherwise go to APPLY; busy=1 from the next cycle.
- APPLY (1 cycle): dut_in <= stim[index]; wait counter <= LATENCY. Next state is WAIT if LATENCY>0, else CHECK.
- WAIT: decrement the counter each cycle; go to CHECK when it reaches 1. WAIT occupies exactly LATENCY cycles.
- CHECK (1 cycle):
  - diff = (dut_out ^ expected[index]) & mask[index]. diff != 0 means error.
  - On error, err_count increments, saturating at 2^CNT_W-1.
  - On the first error, first_err_valid<=1, first_err_idx<=index, first_err_bits<=diff.
  - If index==n-1, or (error && stop_on_error), go to DONE. Otherwise index++ and go to APPLY.
- Cost is 2+LATENCY cycles per vector. done rises 1+k*(2+LATENCY) cycles after the start sample for k vectors checked.
- DONE: busy=0, done=1, pass = (err_count==0) && !aborted, registered on entry. dut_in holds its last value.
- abort=1 in APPLY/WAIT/CHECK: go to DONE next cycle with aborted=1, pass=0, and no check of the current vector. abort in IDLE/DONE is ignored.
- abort and start in the same cycle while IDLE/DONE: start wins.
- ld_en while busy is ignored. A load to the same address as the current read is not possible, since loads only happen while idle.
- start while busy is ignored.
- Mask bit 0 = don't care. An all-zero mask always passes.

Decomposition:
- Package tv_pkg:
  - state enum tv_state_e {IDLE, APPLY, WAIT, CHECK, DONE}.
  - Field offset/width functions for unpacking the vector word by IN_W/OUT_W.
- Sub-module tv_mem: DEPTH x (IN_W+2*OUT_W) storage, one synchronous write port, one asynchronous read port.
- The FSM and counters live in tv_checker.

Test Plan:
Common setup: IN_W=4, OUT_W=4, DEPTH=8, LATENCY=0. The bench DUT is dut_out = ~dut_in.
- Clean run: load 4 vectors stim 0..3, expected ~stim, mask 4'hF; num_vec=4 -> done rises 9 cycles after start; pass=1; err_count=0; first_err_valid=0.
- Errors: num_vec=6; vectors 2 and 5 have expected off by bit 1 -> err_count=2, first_err_idx=2, first_err_bits=4'b0010, pass=0. Same load with mask 4'b1101 on those vectors -> pass=1.
- Stop on error: stop_on_error=1, error at index 1 -> done 5 cycles after start, err_count=1. Then abort mid-run at index 2 -> aborted=1, pass=0 next cycle.
- Boundaries:
  - num_vec=0 -> done next cycle, pass=1.
  - num_vec=12 -> exactly 8 vectors checked (done at cycle 17).
  - CNT_W=2 with 5 errors -> err_count=3.
  - ld_en during busy leaves memory unchanged.
- LATENCY=2 with a 2-stage registered inverter DUT: 3 correct vectors -> pass=1, done at cycle 13. The same DUT with LATENCY=1 -> err_count>0.
- Async reset: pull reset_n low mid-WAIT -> all outputs 0 immediately, without waiting for clk. After release, start reruns correctly from the retained memory.
